// File: rtl/uart_req_scheduler.sv
// Two-requester frame scheduler for a shared UART TX core with ack, timeout and retry.
// Define UART_SCHED_CHECKSUM_EN to append a checksum byte (byte1 ^ byte2 ^ 8'h5A) to each frame.
module uart_req_scheduler #(
    parameter int CLK_FREQ           = 25_000_000,
    parameter int ACK_TIMEOUT_CYCLES = CLK_FREQ / 10,
    parameter int MAX_RETRY          = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [7:0] a_byte1,
    input  logic [7:0] a_byte2,
    output logic       a_ready,
    output logic       a_done,
    output logic       a_err,
    input  logic       b_valid,
    input  logic [7:0] b_byte1,
    input  logic [7:0] b_byte2,
    output logic       b_ready,
    output logic       b_done,
    output logic       b_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       ack_pulse,
    output logic       busy
);

`ifdef UART_SCHED_CHECKSUM_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif
    localparam int TW = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX   = TW'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [1:0]    LAST_IDX  = 2'(NBYTES - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_ACK
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
`ifdef UART_SCHED_CHECKSUM_EN
    logic [7:0]    ck_q, ck_d;
`endif
    logic          a_ready_q, a_ready_d;
    logic          a_done_q, a_done_d;
    logic          a_err_q, a_err_d;
    logic          b_ready_q, b_ready_d;
    logic          b_done_q, b_done_d;
    logic          b_err_q, b_err_d;

    // owner/last_grant encoding: 0 = A, 1 = B
    logic       grant_a;
    logic [7:0] sel1;
    logic [7:0] sel2;

    assign grant_a = a_valid & (~b_valid | last_q);
    assign sel1    = grant_a ? a_byte1 : b_byte1;
    assign sel2    = grant_a ? a_byte2 : b_byte2;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
`ifdef UART_SCHED_CHECKSUM_EN
        ck_d      = ck_q;
`endif
        a_ready_d = 1'b0;
        a_done_d  = 1'b0;
        a_err_d   = 1'b0;
        b_ready_d = 1'b0;
        b_done_d  = 1'b0;
        b_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    owner_d   = ~grant_a;
                    last_d    = ~grant_a;
                    a_ready_d = grant_a;
                    b_ready_d = ~grant_a;
                    b0_d      = sel1;
                    b1_d      = sel2;
`ifdef UART_SCHED_CHECKSUM_EN
                    ck_d      = sel1 ^ sel2 ^ 8'h5A;
`endif
                    idx_d     = 2'd0;
                    retry_d   = 3'd0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end else begin
                        tmo_d   = '0;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // ack takes priority over a timeout landing in the same cycle
                if (ack_pulse) begin
                    a_done_d = ~owner_q;
                    b_done_d = owner_q;
                    state_d  = IDLE;
                end else if (tmo_q == TMO_MAX) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        idx_d   = 2'd0;
                        state_d = SEND;
                    end else begin
                        a_err_d = ~owner_q;
                        b_err_d = owner_q;
                        state_d = IDLE;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            idx_q     <= 2'd0;
            retry_q   <= 3'd0;
            tmo_q     <= '0;
            b0_q      <= 8'h00;
            b1_q      <= 8'h00;
`ifdef UART_SCHED_CHECKSUM_EN
            ck_q      <= 8'h00;
`endif
            a_ready_q <= 1'b0;
            a_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_ready_q <= 1'b0;
            b_done_q  <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
`ifdef UART_SCHED_CHECKSUM_EN
            ck_q      <= ck_d;
`endif
            a_ready_q <= a_ready_d;
            a_done_q  <= a_done_d;
            a_err_q   <= a_err_d;
            b_ready_q <= b_ready_d;
            b_done_q  <= b_done_d;
            b_err_q   <= b_err_d;
        end
    end

    // idx only moves on entry to SEND, so tx_data holds between transmissions
    always_comb begin
        tx_data = 8'h00;
        case (idx_q)
            2'd0: tx_data = b0_q;
            2'd1: tx_data = b1_q;
`ifdef UART_SCHED_CHECKSUM_EN
            2'd2: tx_data = ck_q;
`endif
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_start = (state_q == SEND);
    assign busy     = (state_q != IDLE);
    assign a_ready  = a_ready_q;
    assign a_done   = a_done_q;
    assign a_err    = a_err_q;
    assign b_ready  = b_ready_q;
    assign b_done   = b_done_q;
    assign b_err    = b_err_q;

endmodule

// File: tb/tb_uart_req_scheduler.sv
// Directed bench for uart_req_scheduler with a UART TX model (tx_done 5 cycles after tx_start).
// Define UART_SCHED_CHECKSUM_EN to build the 3-byte frame variant.
module tb_uart_req_scheduler;

`ifdef UART_SCHED_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int TMO    = 20;
    localparam int TXLAT  = 5;
    localparam int BYTE_T = TXLAT + 1;
    localparam int ATT    = NB * BYTE_T + TMO;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [7:0] a_byte1 = 8'h00;
    logic [7:0] a_byte2 = 8'h00;
    logic       a_ready, a_done, a_err;
    logic       b_valid = 1'b0;
    logic [7:0] b_byte1 = 8'h00;
    logic [7:0] b_byte2 = 8'h00;
    logic       b_ready, b_done, b_err;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       ack_pulse = 1'b0;
    logic       busy;

    int ncmp = 0;
    int nfail = 0;

    int cyc = 0;
    int ntx = 0;
    int ndone = 0;
    int dcyc = 0;
    int nad = 0;
    int nae = 0;
    int nbd = 0;
    int nbe = 0;
    int aec = 0;
    int ucnt = 0;
    logic [7:0] txd [0:63];
    int         txc [0:63];

    uart_req_scheduler #(
        .CLK_FREQ(25_000_000),
        .ACK_TIMEOUT_CYCLES(TMO),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_byte1(a_byte1),
        .a_byte2(a_byte2),
        .a_ready(a_ready),
        .a_done(a_done),
        .a_err(a_err),
        .b_valid(b_valid),
        .b_byte1(b_byte1),
        .b_byte2(b_byte2),
        .b_ready(b_ready),
        .b_done(b_done),
        .b_err(b_err),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .ack_pulse(ack_pulse),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log plus UART TX model, both sampled mid-cycle
    always @(negedge clk) begin
        if (tx_start && ntx < 64) begin
            txd[ntx] <= tx_data;
            txc[ntx] <= cyc;
        end
        if (tx_start) ntx <= ntx + 1;
        if (a_done) nad <= nad + 1;
        if (a_err) begin
            nae <= nae + 1;
            aec <= cyc;
        end
        if (b_done) nbd <= nbd + 1;
        if (b_err) nbe <= nbe + 1;
        tx_done <= 1'b0;
        if (tx_start) begin
            ucnt <= TXLAT;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) begin
                tx_done <= 1'b1;
                ndone <= ndone + 1;
                dcyc <= cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] x, input logic [7:0] y, input int i);
        if (i == 0) return x;
        if (i == 1) return y;
        return x ^ y ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        ack_pulse = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_after_done(input int target, input int k, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ndone >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            while (cyc < dcyc + k) tick();
        end
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        rst_n = 1'b0;
        tick();
        outs = {a_ready, a_done, a_err, b_ready, b_done, b_err, tx_start, busy, tx_data};
        ncmp++; if (outs !== 16'h0000) begin nfail++; $display("FAIL reset.outputs got %h want 0000", outs); end
        rst_n = 1'b1;
        tick();
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset.idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single_a(input logic [7:0] x, input logic [7:0] y);
        int n0, nd0, d0, e0;
        logic ok;
        n0 = ntx; nd0 = ndone; d0 = nad; e0 = nae;
        a_byte1 = x; a_byte2 = y; a_valid = 1'b1;
        tick();
        ncmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin nfail++; $display("FAIL single.ready got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
        ncmp++; if (tx_start !== 1'b1 || tx_data !== x) begin nfail++; $display("FAIL single.first_tx got start=%b data=%h want 1 %h", tx_start, tx_data, x); end
        a_valid = 1'b0;
        wait_after_done(nd0 + NB, 3, ok);
        ncmp++; if (ok !== 1'b1) begin nfail++; $display("FAIL single.wait_txdone got timeout want %0d tx_done", NB); end
        ack_pulse = 1'b1;
        tick();
        ack_pulse = 1'b0;
        ncmp++; if (a_done !== 1'b1 || busy !== 1'b0) begin nfail++; $display("FAIL single.done got done=%b busy=%b want 1 0", a_done, busy); end
        tick();
        ncmp++; if (a_done !== 1'b0) begin nfail++; $display("FAIL single.done_pulse got %b want 0", a_done); end
        ncmp++; if (ntx - n0 !== NB) begin nfail++; $display("FAIL single.tx_count got %0d want %0d", ntx - n0, NB); end
        for (int i = 0; i < NB; i++) begin
            ncmp++; if (txd[n0+i] !== exp_byte(x, y, i)) begin nfail++; $display("FAIL single.byte%0d got %h want %h", i, txd[n0+i], exp_byte(x, y, i)); end
        end
        ncmp++; if (txc[n0+1] - txc[n0] !== BYTE_T) begin nfail++; $display("FAIL single.byte_gap got %0d want %0d", txc[n0+1] - txc[n0], BYTE_T); end
        ncmp++; if (nad - d0 !== 1 || nae !== e0) begin nfail++; $display("FAIL single.counts got done=%0d err=%0d want 1 0", nad - d0, nae - e0); end
    endtask

    task automatic test_round_robin();
        int nd0;
        logic ok;
        do_reset();
        nd0 = ndone;
        a_byte1 = 8'h11; a_byte2 = 8'h12; b_byte1 = 8'h21; b_byte2 = 8'h22;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        ncmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin nfail++; $display("FAIL rr.first got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
        a_valid = 1'b0;
        wait_after_done(nd0 + NB, 3, ok);
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        ncmp++; if (ok !== 1'b1 || a_done !== 1'b1) begin nfail++; $display("FAIL rr.a_done got ok=%b done=%b want 1 1", ok, a_done); end
        tick();
        ncmp++; if (b_ready !== 1'b1 || tx_data !== 8'h21) begin nfail++; $display("FAIL rr.b_grant got ready=%b data=%h want 1 21", b_ready, tx_data); end
        b_valid = 1'b0;
        wait_after_done(nd0 + 2 * NB, 3, ok);
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        ncmp++; if (ok !== 1'b1 || b_done !== 1'b1 || a_done !== 1'b0) begin nfail++; $display("FAIL rr.b_done got ok=%b b=%b a=%b want 1 1 0", ok, b_done, a_done); end
        a_byte1 = 8'h31; b_byte1 = 8'h41;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        ncmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || tx_data !== 8'h31) begin nfail++; $display("FAIL rr.second got a=%b b=%b data=%h want 1 0 31", a_ready, b_ready, tx_data); end
        a_valid = 1'b0;
        wait_after_done(nd0 + 3 * NB, 3, ok);
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        tick();
        ncmp++; if (b_ready !== 1'b1 || tx_data !== 8'h41) begin nfail++; $display("FAIL rr.b_again got ready=%b data=%h want 1 41", b_ready, tx_data); end
        b_valid = 1'b0;
        wait_after_done(nd0 + 4 * NB, 3, ok);
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        ncmp++; if (ok !== 1'b1 || b_done !== 1'b1) begin nfail++; $display("FAIL rr.b_done2 got ok=%b done=%b want 1 1", ok, b_done); end
    endtask

    task automatic test_no_ack();
        int n0, d0, e0;
        logic ok;
        n0 = ntx; d0 = nad; e0 = nae;
        a_byte1 = 8'h33; a_byte2 = 8'h44; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3 * ATT + 40; i++) begin
            if (nae > e0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        ncmp++; if (ok !== 1'b1) begin nfail++; $display("FAIL noack.err_seen got timeout want a_err"); end
        ncmp++; if (ntx - n0 !== 3 * NB) begin nfail++; $display("FAIL noack.tx_count got %0d want %0d", ntx - n0, 3 * NB); end
        for (int i = 0; i < 3 * NB; i++) begin
            ncmp++; if (txd[n0+i] !== exp_byte(8'h33, 8'h44, i % NB)) begin nfail++; $display("FAIL noack.byte%0d got %h want %h", i, txd[n0+i], exp_byte(8'h33, 8'h44, i % NB)); end
        end
        ncmp++; if (txc[n0+NB] - txc[n0] !== ATT) begin nfail++; $display("FAIL noack.retry1_gap got %0d want %0d", txc[n0+NB] - txc[n0], ATT); end
        ncmp++; if (txc[n0+2*NB] - txc[n0+NB] !== ATT) begin nfail++; $display("FAIL noack.retry2_gap got %0d want %0d", txc[n0+2*NB] - txc[n0+NB], ATT); end
        ncmp++; if (aec - txc[n0] !== 3 * ATT) begin nfail++; $display("FAIL noack.err_time got %0d want %0d", aec - txc[n0], 3 * ATT); end
        repeat (5) tick();
        ncmp++; if (nae - e0 !== 1 || nad !== d0 || busy !== 1'b0) begin nfail++; $display("FAIL noack.final got err=%0d done=%0d busy=%b want 1 0 0", nae - e0, nad - d0, busy); end
    endtask

    task automatic test_stale_ack();
        int n0, nd0, d0, e0;
        logic ok;
        n0 = ntx; nd0 = ndone; d0 = nad; e0 = nae;
        a_byte1 = 8'h66; a_byte2 = 8'h77; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        wait_after_done(nd0 + 2 * NB, 3, ok);
        ncmp++; if (ok !== 1'b1 || nad !== d0) begin nfail++; $display("FAIL stale.ignored got ok=%b done=%0d want 1 0", ok, nad - d0); end
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        ncmp++; if (a_done !== 1'b1 || a_err !== 1'b0) begin nfail++; $display("FAIL stale.done got done=%b err=%b want 1 0", a_done, a_err); end
        ncmp++; if (ntx - n0 !== 2 * NB) begin nfail++; $display("FAIL stale.tx_count got %0d want %0d", ntx - n0, 2 * NB); end
        ncmp++; if (txc[n0+NB] - txc[n0] !== ATT) begin nfail++; $display("FAIL stale.retry_gap got %0d want %0d", txc[n0+NB] - txc[n0], ATT); end
        repeat (3) tick();
        ncmp++; if (nae !== e0 || nad - d0 !== 1) begin nfail++; $display("FAIL stale.counts got err=%0d done=%0d want 0 1", nae - e0, nad - d0); end
    endtask

    task automatic test_reset_mid();
        int nd0, bd0, be0;
        logic ok;
        logic [15:0] outs;
        nd0 = ndone; bd0 = nbd; be0 = nbe;
        b_byte1 = 8'h21; b_byte2 = 8'h43; b_valid = 1'b1;
        tick();
        ncmp++; if (b_ready !== 1'b1 || tx_data !== 8'h21) begin nfail++; $display("FAIL rstmid.b_grant got ready=%b data=%h want 1 21", b_ready, tx_data); end
        b_valid = 1'b0;
        a_byte1 = 8'h5C; a_byte2 = 8'hC5; a_valid = 1'b1;
        wait_after_done(nd0 + NB, 3, ok);
        ncmp++; if (ok !== 1'b1 || busy !== 1'b1 || a_ready !== 1'b0) begin nfail++; $display("FAIL rstmid.in_wait got ok=%b busy=%b a_ready=%b want 1 1 0", ok, busy, a_ready); end
        rst_n = 1'b0;
        b_valid = 1'b1;
        #1;
        outs = {a_ready, a_done, a_err, b_ready, b_done, b_err, tx_start, busy, tx_data};
        ncmp++; if (outs !== 16'h0000) begin nfail++; $display("FAIL rstmid.outputs got %h want 0000", outs); end
        tick();
        tick();
        ncmp++; if (nbd !== bd0 || nbe !== be0) begin nfail++; $display("FAIL rstmid.no_done got done=%0d err=%0d want 0 0", nbd - bd0, nbe - be0); end
        rst_n = 1'b1;
        tick();
        ncmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || tx_data !== 8'h5C) begin nfail++; $display("FAIL rstmid.a_first got a=%b b=%b data=%h want 1 0 5c", a_ready, b_ready, tx_data); end
        a_valid = 1'b0;
        b_valid = 1'b0;
        do_reset();
    endtask

`ifdef UART_SCHED_CHECKSUM_EN
    task automatic test_checksum();
        int n0, nd0;
        logic ok;
        n0 = ntx; nd0 = ndone;
        a_byte1 = 8'h0A; a_byte2 = 8'h00; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        wait_after_done(nd0 + 3, 3, ok);
        ack_pulse = 1'b1; tick(); ack_pulse = 1'b0;
        ncmp++; if (ok !== 1'b1 || a_done !== 1'b1) begin nfail++; $display("FAIL cksum.done got ok=%b done=%b want 1 1", ok, a_done); end
        ncmp++; if (ntx - n0 !== 3) begin nfail++; $display("FAIL cksum.count got %0d want 3", ntx - n0); end
        ncmp++; if ({txd[n0], txd[n0+1], txd[n0+2]} !== 24'h0A0050) begin nfail++; $display("FAIL cksum.bytes got %h %h %h want 0a 00 50", txd[n0], txd[n0+1], txd[n0+2]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_a(8'h05, 8'h00);
        test_round_robin();
        test_no_ack();
        test_stale_ack();
        test_reset_mid();
`ifdef UART_SCHED_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
